ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Multi-cycle control sequencer for the 9-bit-class CPU: latches one instruction per handshake, decodes its opcode field, and drives registered one-cycle control strobes for register file, data memory, move path and branch logic. Variable-latency loads are handled by an internal wait counter. Reaching HALT raises a sticky `Ack`. It sits between the instruction ROM/PC and the datapath.

## Interface
- `IW`, 9: instruction width; opcode is `Instruction[IW-1:IW-3]`, `TargSel` is `Instruction[IW-4:IW-5]`. Legal range is `IW >= 6`.
- `LOAD_LAT`, 1: data-memory read latency in cycles. Legal range is 1..15.
- `CW`, 16: width of the retired-instruction counter.
- `Clk` input 1: clock, rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `Start` input 1: one-cycle pulse that starts or restarts program execution.
- `Instruction` input IW: machine code, qualified by `InstValid`.
- `InstValid` input 1: instruction word is valid this cycle.
- `Zero` input 1: ALU zero flag, sampled in EXEC.
- `InstReady` output 1: the sequencer accepts `Instruction` this cycle.
- `RegWrEn`, `MovEn`, `MemWrEn`, `StoreInst`, `LoadInst`, `BranchEn`, `Jump` output 1 each: control strobes.
- `TargSel` output 2: branch LUT select, latched from the IR.
- `PcEn` output 1: one-cycle PC advance. Advance is PC+1, or the branch target when `Jump` is high.
- `Busy` output 1: high in any state other than IDLE and DONE.
- `Ack` output 1: program done. Sticky.
- `InstCount` output CW: number of retired instructions. Saturates at all-ones.

## Operation
- **Opcode map** (`op` = top 3 bits):
  - 011 LOAD.
  - 101 MOV.
  - 110 STORE.
  - 111 BRANCH.
  - All other values are ALU ops.
  - An all-ones instruction is HALT and takes precedence over BRANCH.
- **States:** IDLE, FETCH, DECODE, EXEC, MEMWAIT, DONE.
- **IDLE:** `Start` moves to FETCH.
- **FETCH:** `InstReady`=1. When `InstValid` is high, latch IR and go to DECODE. Otherwise stay in FETCH.
- **DECODE:**
  - HALT goes to DONE.
  - LOAD loads the wait counter with `LOAD_LAT` and goes to MEMWAIT.
  - Everything else goes to EXEC.
- **EXEC:** one cycle of strobes, then back to FETCH.
  - ALU or MOV: `RegWrEn`=1. `MovEn`=1 only for MOV.
  - STORE: `MemWrEn`=`StoreInst`=1, `RegWrEn`=0.
  - BRANCH: `BranchEn`=1, `Jump`=`Zero`, `RegWrEn`=0.
  - `PcEn`=1 for all of the above.
  - `InstCount` increments.
- **MEMWAIT:**
  - `LoadInst`=1 in every cycle.
  - The counter decrements each cycle.
  - In the cycle the counter reaches 1, assert `RegWrEn`=1 and `PcEn`=1, increment `InstCount`, and go to FETCH.
- **DONE:**
  - `Ack`=1 and all strobes are 0. `PcEn` is not pulsed, so PC stays on HALT.
  - HALT is not counted in `InstCount`.
  - `Start` clears `Ack` and `InstCount` and goes to FETCH.
- `TargSel` reflects `IR[IW-4:IW-5]` from DECODE onward and holds until the next IR load.
- Every strobe except `TargSel` is 0 outside EXEC and MEMWAIT.
- `Start` is ignored in FETCH, DECODE, EXEC and MEMWAIT.
- `InstValid` is ignored outside FETCH.

## Timing
- All outputs are registered or derived purely from state. No input-to-output combinational path exists, except `InstReady`, which is a decode of state.
- **Reset:** on `Reset_n`=0, immediately force state=IDLE, all strobes=0, `TargSel`=0, `Ack`=0, `Busy`=0, `InstCount`=0, IR=0, and the wait counter to 0.
- **Latency for non-load instructions:** `Start` at cycle 0 gives FETCH at cycle 1. With `InstValid` high in cycle 1: DECODE at cycle 2, EXEC strobes at cycle 3, next FETCH at cycle 4. Throughput is 3 cycles per instruction.
- **Load latency:** FETCH, DECODE, then `LOAD_LAT` cycles of MEMWAIT, giving `2+LOAD_LAT` cycles per load. With `LOAD_LAT`=1, `LoadInst` and `RegWrEn` are both high in the single MEMWAIT cycle.
- **HALT:** `Ack` rises 2 cycles after the FETCH handshake (FETCH → DECODE → DONE).
- **`Start` in the same cycle as HALT entry:** the transition to DONE takes priority; the `Start` pulse is dropped.
- **Reset mid-MEMWAIT:** no `RegWrEn` pulse is issued afterwards.
- **`InstCount` saturation:** at 2^CW-1, further retirements leave the counter unchanged. No wrap.

## Test plan
- **ALU op:** reset, `Start`, then `Instruction`=9'b000_01_0011 held valid. `RegWrEn`=1 for exactly one cycle at cycle 3, `PcEn` in the same cycle, `InstCount`=1, FETCH at cycle 4.
- **Store and branch:** STORE 9'b110_00_0001 gives `MemWrEn`=`StoreInst`=1 and `RegWrEn`=0. BRANCH 9'b111_10_0000 with `Zero`=1 gives `BranchEn`=1, `Jump`=1, `TargSel`=2'b10. Repeat with `Zero`=0: `Jump`=0, `BranchEn`=1.
- **Load latency:** `LOAD_LAT`=3, LOAD 9'b011_00_0100. `LoadInst` high for exactly 3 cycles, `RegWrEn` and `PcEn` only in the 3rd. Total 5 cycles from FETCH handshake to the next FETCH.
- **FETCH stall and HALT:**
  - Hold `InstValid`=0 for 4 cycles in FETCH. `InstReady` stays high, no state change, no strobes.
  - Then present 9'h1FF. `Ack`=1 two cycles later, `Busy`=0, `InstCount` unchanged, `Ack` held for 10+ cycles.
  - `Start` then clears `Ack` and `InstCount`.
- **Async reset mid-load:** assert `Reset_n`=0 in the 2nd MEMWAIT cycle, between clock edges. All outputs are 0 before the next edge, there is no later `RegWrEn` pulse, and the block is in IDLE after release.
- **Saturation:** `CW`=2, run 5 ALU ops. `InstCount` reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: fetch/decode/execute FSM driving registered
// one-cycle control strobes, with a wait counter for variable-latency loads.
module ctrl_seq #(
    parameter int unsigned IW       = 9,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CW       = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [IW-1:0] Instruction,
    input  logic          InstValid,
    input  logic          Zero,
    output logic          InstReady,
    output logic          RegWrEn,
    output logic          MovEn,
    output logic          MemWrEn,
    output logic          StoreInst,
    output logic          LoadInst,
    output logic          BranchEn,
    output logic          Jump,
    output logic [1:0]    TargSel,
    output logic          PcEn,
    output logic          Busy,
    output logic          Ack,
    output logic [CW-1:0] InstCount
);

    localparam logic [2:0] OpLoad   = 3'b011;
    localparam logic [2:0] OpMov    = 3'b101;
    localparam logic [2:0] OpStore  = 3'b110;
    localparam logic [2:0] OpBranch = 3'b111;
    localparam logic [3:0] LatInit  = 4'(LOAD_LAT);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMemWait,
        StDone
    } state_e;

    state_e        state;
    logic [IW-1:0] ir;
    logic [3:0]    wcnt;
    logic [2:0]    op;
    logic          is_halt;
    logic [CW-1:0] count_inc;

    assign op        = ir[IW-1:IW-3];
    assign is_halt   = &ir;
    assign count_inc = (&InstCount) ? InstCount : InstCount + CW'(1);

    assign InstReady = (state == StFetch);
    assign Busy      = (state != StIdle) && (state != StDone);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= StIdle;
            ir        <= '0;
            wcnt      <= '0;
            RegWrEn   <= 1'b0;
            MovEn     <= 1'b0;
            MemWrEn   <= 1'b0;
            StoreInst <= 1'b0;
            LoadInst  <= 1'b0;
            BranchEn  <= 1'b0;
            Jump      <= 1'b0;
            PcEn      <= 1'b0;
            TargSel   <= 2'b00;
            Ack       <= 1'b0;
            InstCount <= '0;
        end else begin
            // Strobes are one-cycle pulses unless re-armed below.
            RegWrEn   <= 1'b0;
            MovEn     <= 1'b0;
            MemWrEn   <= 1'b0;
            StoreInst <= 1'b0;
            LoadInst  <= 1'b0;
            BranchEn  <= 1'b0;
            Jump      <= 1'b0;
            PcEn      <= 1'b0;

            case (state)
                StIdle: begin
                    if (Start) begin
                        state <= StFetch;
                    end
                end
                StFetch: begin
                    if (InstValid) begin
                        ir      <= Instruction;
                        TargSel <= Instruction[IW-4:IW-5];
                        state   <= StDecode;
                    end
                end
                StDecode: begin
                    if (is_halt) begin
                        Ack   <= 1'b1;
                        state <= StDone;
                    end else if (op == OpLoad) begin
                        wcnt     <= LatInit;
                        LoadInst <= 1'b1;
                        state    <= StMemWait;
                        if (LatInit == 4'd1) begin
                            RegWrEn   <= 1'b1;
                            PcEn      <= 1'b1;
                            InstCount <= count_inc;
                        end
                    end else begin
                        PcEn      <= 1'b1;
                        InstCount <= count_inc;
                        state     <= StExec;
                        case (op)
                            OpMov: begin
                                RegWrEn <= 1'b1;
                                MovEn   <= 1'b1;
                            end
                            OpStore: begin
                                MemWrEn   <= 1'b1;
                                StoreInst <= 1'b1;
                            end
                            OpBranch: begin
                                BranchEn <= 1'b1;
                                Jump     <= Zero;
                            end
                            default: RegWrEn <= 1'b1;
                        endcase
                    end
                end
                StExec: begin
                    state <= StFetch;
                end
                StMemWait: begin
                    wcnt <= wcnt - 4'd1;
                    if (wcnt <= 4'd1) begin
                        state <= StFetch;
                    end else begin
                        LoadInst <= 1'b1;
                        // Next cycle is the last wait cycle: retire the load there.
                        if (wcnt == 4'd2) begin
                            RegWrEn   <= 1'b1;
                            PcEn      <= 1'b1;
                            InstCount <= count_inc;
                        end
                    end
                end
                StDone: begin
                    if (Start) begin
                        Ack       <= 1'b0;
                        InstCount <= '0;
                        state     <= StFetch;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: one instance with LOAD_LAT=3 for the main
// sequence, a second with CW=2 for counter saturation.
module tb_ctrl_seq;

    localparam int unsigned IW = 9;

    logic          Clk;
    logic          Reset_n;
    logic          Start, InstValid, Zero;
    logic [IW-1:0] Instruction;
    logic          InstReady, RegWrEn, MovEn, MemWrEn, StoreInst, LoadInst;
    logic          BranchEn, Jump, PcEn, Busy, Ack;
    logic [1:0]    TargSel;
    logic [15:0]   InstCount;

    logic          start_b, valid_b;
    logic [IW-1:0] instr_b;
    logic          ready_b, regwr_b, mov_b, memwr_b, store_b, load_b;
    logic          br_b, jump_b, pcen_b, busy_b, ack_b;
    logic [1:0]    tsel_b;
    logic [1:0]    cnt_b;

    int errors = 0;
    int checks = 0;

    ctrl_seq #(.IW(IW), .LOAD_LAT(3), .CW(16)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Instruction(Instruction),
        .InstValid(InstValid), .Zero(Zero), .InstReady(InstReady), .RegWrEn(RegWrEn),
        .MovEn(MovEn), .MemWrEn(MemWrEn), .StoreInst(StoreInst), .LoadInst(LoadInst),
        .BranchEn(BranchEn), .Jump(Jump), .TargSel(TargSel), .PcEn(PcEn),
        .Busy(Busy), .Ack(Ack), .InstCount(InstCount)
    );

    ctrl_seq #(.IW(IW), .LOAD_LAT(1), .CW(2)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .Start(start_b), .Instruction(instr_b),
        .InstValid(valid_b), .Zero(1'b0), .InstReady(ready_b), .RegWrEn(regwr_b),
        .MovEn(mov_b), .MemWrEn(memwr_b), .StoreInst(store_b), .LoadInst(load_b),
        .BranchEn(br_b), .Jump(jump_b), .TargSel(tsel_b), .PcEn(pcen_b),
        .Busy(busy_b), .Ack(ack_b), .InstCount(cnt_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] strobes();
        return {RegWrEn, MovEn, MemWrEn, StoreInst, LoadInst, BranchEn, Jump, PcEn};
    endfunction

    initial begin
        int exp_sat[5];
        exp_sat = '{1, 2, 3, 3, 3};
        Reset_n = 1'b0; Start = 1'b0; InstValid = 1'b0; Zero = 1'b0; Instruction = '0;
        start_b = 1'b0; valid_b = 1'b0; instr_b = '0;
        tick(); tick();

        chk("rst_ready", InstReady, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_ack", Ack, 0);
        chk("rst_count", InstCount, 0);
        chk("rst_targsel", TargSel, 0);
        chk("rst_strobes", strobes(), 0);
        Reset_n = 1'b1;
        tick();

        // ALU op
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("alu_fetch_ready", InstReady, 1);
        chk("alu_fetch_busy", Busy, 1);
        Instruction = 9'b000_01_0011; InstValid = 1'b1;
        tick();
        InstValid = 1'b0;
        chk("alu_decode_strobes", strobes(), 0);
        chk("alu_decode_targsel", TargSel, 2'b01);
        chk("alu_decode_ready", InstReady, 0);
        tick();
        chk("alu_exec_strobes", strobes(), 8'b1000_0001);
        chk("alu_exec_count", InstCount, 1);
        tick();
        chk("alu_next_fetch", InstReady, 1);
        chk("alu_after_strobes", strobes(), 0);

        // STORE
        Instruction = 9'b110_00_0001; InstValid = 1'b1;
        tick();
        InstValid = 1'b0;
        tick();
        chk("store_exec_strobes", strobes(), 8'b0011_0001);
        chk("store_exec_count", InstCount, 2);
        tick();

        // BRANCH taken
        Instruction = 9'b111_10_0000; InstValid = 1'b1; Zero = 1'b1;
        tick();
        InstValid = 1'b0;
        chk("br1_decode_targsel", TargSel, 2'b10);
        tick();
        chk("br1_exec_strobes", strobes(), 8'b0000_0111);
        chk("br1_exec_targsel", TargSel, 2'b10);
        tick();
        chk("br1_fetch_targsel_hold", TargSel, 2'b10);

        // BRANCH not taken
        Zero = 1'b0; InstValid = 1'b1;
        tick();
        InstValid = 1'b0;
        tick();
        chk("br0_exec_strobes", strobes(), 8'b0000_0101);
        chk("br0_exec_count", InstCount, 4);
        tick();

        // LOAD, latency 3
        Instruction = 9'b011_00_0100; InstValid = 1'b1;
        tick();
        InstValid = 1'b0;
        chk("ld_decode_strobes", strobes(), 0);
        chk("ld_decode_targsel", TargSel, 2'b00);
        tick();
        chk("ld_wait1_strobes", strobes(), 8'b0000_1000);
        tick();
        chk("ld_wait2_strobes", strobes(), 8'b0000_1000);
        chk("ld_wait2_count", InstCount, 4);
        tick();
        chk("ld_wait3_strobes", strobes(), 8'b1000_1001);
        chk("ld_wait3_count", InstCount, 5);
        tick();
        chk("ld_next_fetch", InstReady, 1);
        chk("ld_after_strobes", strobes(), 0);

        // FETCH stall
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_ready", InstReady, 1);
            chk("stall_busy", Busy, 1);
            chk("stall_strobes", strobes(), 0);
        end

        // HALT; a Start during DECODE must be dropped
        Instruction = 9'h1FF; InstValid = 1'b1;
        tick();
        InstValid = 1'b0;
        chk("halt_decode_ack", Ack, 0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("halt_ack", Ack, 1);
        chk("halt_busy", Busy, 0);
        chk("halt_count", InstCount, 5);
        chk("halt_strobes", strobes(), 0);
        chk("halt_ready", InstReady, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_ack_hold", Ack, 1);
            chk("halt_hold_strobes", strobes(), 0);
        end
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("restart_ack", Ack, 0);
        chk("restart_count", InstCount, 0);
        chk("restart_ready", InstReady, 1);

        // Async reset in second MEMWAIT cycle
        Instruction = 9'b011_00_0100; InstValid = 1'b1;
        tick();
        InstValid = 1'b0;
        tick();
        tick();
        chk("arst_pre_load", LoadInst, 1);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("arst_strobes", strobes(), 0);
        chk("arst_busy", Busy, 0);
        chk("arst_ready", InstReady, 0);
        chk("arst_targsel", TargSel, 0);
        chk("arst_count", InstCount, 0);
        tick();
        Reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("arst_post_strobes", strobes(), 0);
            chk("arst_post_idle", {Busy, InstReady}, 0);
        end

        // Saturation on the CW=2 instance
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        instr_b = 9'b000_01_0011; valid_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tick();
            chk("sat_count", cnt_b, exp_sat[i]);
            chk("sat_exec", {regwr_b, pcen_b, busy_b, ready_b, ack_b}, 5'b11100);
            chk("sat_quiet", {mov_b, memwr_b, store_b, load_b, br_b, jump_b, tsel_b}, 8'b0000_0001);
            tick();
        end
        valid_b = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
